win_sched: RTL and testbench

Window scheduler that sequences the frame counter and window output used across the timing blocks. It accepts window configurations (period, window start/end, burst length) over a valid/ready handshake, runs the frame counter for a programmed number of frames or continuously, and swaps in new configurations only at frame boundaries. It sits between the control/register logic and any consumer of a periodic gate signal.

---
 rtl/win_sched_pkg.sv | 23 ++
 rtl/win_sched_frame_cnt.sv | 60 ++++++
 rtl/win_sched.sv | 142 ++++++++++++++
 tb/tb_win_sched.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/win_sched_pkg.sv
// Shared types and defaults for the window scheduler.
// Holds the FSM state enum, the config struct and the reset config.
package win_sched_pkg;

  localparam int WS_CW         = 8;
  localparam int WS_DEF_PERIOD = 20;
  localparam int WS_DEF_START  = 10;
  localparam int WS_DEF_END    = 15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP
  } state_e;

  typedef struct packed {
    logic [WS_CW-1:0] period;
    logic [WS_CW-1:0] wstart;
    logic [WS_CW-1:0] wend;
    logic [7:0]       bursts;
  } cfg_t;

endpackage

// File: rtl/win_sched_frame_cnt.sv
// Frame counter, wrap detect and window compare for win_sched.
// Ports: run/run_n (current/next busy), active and next config, cnt, wrap, win.
// WIN_SCHED_SYNC_OUT_EN: win is a flop fed from next-state count/config.
module win_frame_cnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          run_n,
  input  logic [CW-1:0] per,
  input  logic [CW-1:0] wst,
  input  logic [CW-1:0] wend,
  input  logic [CW-1:0] per_n,
  input  logic [CW-1:0] wst_n,
  input  logic [CW-1:0] wend_n,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          win
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_n;

  assign wrap  = run && (cnt_q == per);
  assign cnt_n = (run && !wrap) ? cnt_q + CW'(1) : '0;
  assign cnt   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_n;
  end

`ifdef WIN_SCHED_SYNC_OUT_EN
  logic win_q;
  logic unused_cur;
  assign unused_cur = ^{wst, wend};

  // Same decode as the comb build, one cycle early, so win_q
  // lines up with the cnt_q value it was computed from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_q <= 1'b0;
    else        win_q <= run_n
                         && (wst_n <= cnt_n)
                         && (cnt_n <= wend_n)
                         && (cnt_n <= per_n);
  end

  assign win = win_q;
`else
  logic unused_nxt;
  assign unused_nxt = ^{run_n, per_n, wst_n, wend_n};

  assign win = run
               && (wst <= cnt_q)
               && (cnt_q <= wend)
               && (cnt_q <= per);
`endif

endmodule

// File: rtl/win_sched.sv
// Window scheduler: FSM, config handshake, shadow config, burst count.
// Ports: start/stop, cfg_* valid/ready, busy, cnt_o, win_out, period_tick, done.
// Optional WIN_SCHED_SYNC_OUT_EN registers win_out (see win_frame_cnt).
module win_sched
  import win_sched_pkg::*;
#(
  parameter int CW         = WS_CW,
  parameter int DEF_PERIOD = WS_DEF_PERIOD,
  parameter int DEF_START  = WS_DEF_START,
  parameter int DEF_END    = WS_DEF_END
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_period,
  input  logic [CW-1:0] cfg_start,
  input  logic [CW-1:0] cfg_end,
  input  logic [7:0]    cfg_bursts,
  output logic          busy,
  output logic [CW-1:0] cnt_o,
  output logic          win_out,
  output logic          period_tick,
  output logic          done
);

  localparam cfg_t DEF_CFG = '{
    period: WS_CW'(DEF_PERIOD),
    wstart: WS_CW'(DEF_START),
    wend:   WS_CW'(DEF_END),
    bursts: 8'd0
  };

  state_e     state_q, state_n;
  cfg_t       act_q, act_n;
  cfg_t       shd_q, shd_n;
  logic       shd_full_q, shd_full_n;
  logic [7:0] frm_q, frm_n;
  logic       done_q, done_n;

  logic run, run_n, wrap, xfer, last_frm;
  cfg_t cfg_in;

  assign run       = (state_q != S_IDLE);
  assign run_n     = (state_n != S_IDLE);
  assign cfg_ready = !run || !shd_full_q;
  assign xfer      = cfg_valid && cfg_ready;

  assign cfg_in = '{
    period: cfg_period,
    wstart: cfg_start,
    wend:   cfg_end,
    bursts: cfg_bursts
  };

  // 9-bit compare so bursts = 255 cannot alias through overflow.
  assign last_frm = (act_q.bursts != 8'd0)
                    && (({1'b0, frm_q} + 9'd1)
                        == {1'b0, act_q.bursts});

  always_comb begin
    state_n    = state_q;
    act_n      = act_q;
    shd_n      = shd_q;
    shd_full_n = shd_full_q;
    frm_n      = frm_q;
    done_n     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        shd_full_n = 1'b0;
        frm_n      = '0;
        // A word accepted on the final wrap is left in the
        // shadow; promote it here unless a new word overrides.
        if (xfer)            act_n = cfg_in;
        else if (shd_full_q) act_n = shd_q;
        if (start) state_n = S_RUN;
      end
      S_RUN, S_STOP: begin
        if (xfer) begin
          shd_n      = cfg_in;
          shd_full_n = 1'b1;
        end
        if (state_q == S_RUN && stop) state_n = S_STOP;
        if (wrap) begin
          frm_n = frm_q + 8'd1;
          if (shd_full_q) begin
            act_n      = shd_q;
            shd_full_n = 1'b0;
            frm_n      = '0;
          end
          if (last_frm || state_q == S_STOP || stop) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            frm_n   = '0;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      act_q      <= DEF_CFG;
      shd_q      <= '0;
      shd_full_q <= 1'b0;
      frm_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      act_q      <= act_n;
      shd_q      <= shd_n;
      shd_full_q <= shd_full_n;
      frm_q      <= frm_n;
      done_q     <= done_n;
    end
  end

  win_frame_cnt #(.CW(CW)) u_frame_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .run_n  (run_n),
    .per    (act_q.period),
    .wst    (act_q.wstart),
    .wend   (act_q.wend),
    .per_n  (act_n.period),
    .wst_n  (act_n.wstart),
    .wend_n (act_n.wend),
    .cnt    (cnt_o),
    .wrap   (wrap),
    .win    (win_out)
  );

  assign busy        = run;
  assign period_tick = wrap;
  assign done        = done_q;

endmodule

// File: tb/tb_win_sched.sv
// Self-checking bench for win_sched: directed scenarios plus random
// traffic, all compared against a behavioural frame/queue model.
module tb_win_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, cfg_valid, cfg_ready;
  logic [7:0] cfg_period, cfg_start, cfg_end, cfg_bursts;
  logic       busy, win_out, period_tick, done;
  logic [7:0] cnt_o;

  win_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_start   (cfg_start),
    .cfg_end     (cfg_end),
    .cfg_bursts  (cfg_bursts),
    .busy        (busy),
    .cnt_o       (cnt_o),
    .win_out     (win_out),
    .period_tick (period_tick),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  typedef struct {
    int p;
    int s;
    int e;
    int b;
  } mcfg_t;

  // model: 0 idle, 1 running, 2 finishing after stop
  int    m_st;
  int    m_cnt;
  int    m_frm;
  bit    m_done;
  mcfg_t act;
  mcfg_t shq[$];

  function automatic void m_reset();
    m_st   = 0;
    m_cnt  = 0;
    m_frm  = 0;
    m_done = 0;
    act    = '{20, 10, 15, 0};
    shq.delete();
  endfunction

  function automatic bit m_ready();
    return (m_st == 0) || (shq.size() == 0);
  endfunction

  function automatic void m_edge(bit st, bit sp, bit v, mcfg_t c);
    bit xfer;
    bit fin;
    xfer   = v && m_ready();
    m_done = 0;
    if (m_st == 0) begin
      if (xfer) act = c;
      else if (shq.size() > 0) act = shq.pop_front();
      shq.delete();
      if (st) begin
        m_st  = 1;
        m_cnt = 0;
        m_frm = 0;
      end
    end else begin
      if (m_cnt == act.p) begin
        fin = (act.b != 0 && m_frm + 1 >= act.b)
              || m_st == 2 || sp;
        m_frm++;
        m_cnt = 0;
        if (shq.size() > 0) begin
          act   = shq.pop_front();
          m_frm = 0;
        end
        if (fin) begin
          m_st   = 0;
          m_done = 1;
          m_frm  = 0;
        end
      end else begin
        m_cnt++;
        if (sp && m_st == 1) m_st = 2;
      end
      if (xfer) shq.push_back(c);
    end
  endfunction

  task automatic compare_all();
    bit on;
    on = (m_st != 0);
    chk("busy", busy, on);
    chk("cnt", cnt_o, m_cnt);
    chk("tick", period_tick, on && m_cnt == act.p);
    chk("win", win_out, on && m_cnt >= act.s
                         && m_cnt <= act.e && m_cnt <= act.p);
    chk("ready", cfg_ready, m_ready());
    chk("done", done, m_done);
  endtask

  task automatic cyc(bit st, bit sp, bit v,
                     int p, int s, int e, int b);
    mcfg_t c;
    c = '{p & 255, s & 255, e & 255, b & 255};
    start      = st;
    stop       = sp;
    cfg_valid  = v;
    cfg_period = p[7:0];
    cfg_start  = s[7:0];
    cfg_end    = e[7:0];
    cfg_bursts = b[7:0];
    @(posedge clk);
    m_edge(st, sp, v, c);
    #1;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    compare_all();
  endtask

  task automatic idle1();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 600) begin
      idle1();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_cnt(input string tag, input int v);
    int n;
    n = 0;
    while (cnt_o != v[7:0] && n < 600) begin
      idle1();
      n++;
    end
    chk(tag, cnt_o, v);
  endtask

  initial begin
    int wc, tc, n;
    rst_n      = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_start  = '0;
    cfg_end    = '0;
    cfg_bursts = '0;
    m_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // defaults: 21-cycle frame, window 10..15
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("first_cnt", cnt_o, 0);
    wc = 0;
    tc = 0;
    repeat (21) begin
      idle1();
      wc += int'(win_out);
      tc += int'(period_tick);
    end
    chk("def_win_per_frame", wc, 6);
    chk("def_tick_per_frame", tc, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    wait_idle("def_stop_idle");

    // burst: 3 frames of 5
    cyc(0, 0, 1, 4, 1, 2, 3);
    cyc(1, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (busy && n < 100) begin
      idle1();
      n++;
    end
    chk("burst_len", n, 15);
    chk("burst_done", done, 1);
    chk("burst_cnt", cnt_o, 0);

    // shadow config swap at the wrap
    cyc(0, 0, 1, 9, 0, 4, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    wait_cnt("reach_cnt5", 5);
    cyc(0, 0, 1, 3, 1, 2, 0);
    chk("shadow_ready", cfg_ready, 0);
    cyc(0, 0, 1, 7, 7, 7, 0);
    wait_cnt("reach_cnt9", 9);
    idle1();
    tc = 0;
    repeat (8) begin
      idle1();
      tc += int'(period_tick);
    end
    chk("shadow_ticks", tc, 2);
    cyc(0, 1, 0, 0, 0, 0, 0);
    wait_idle("shadow_idle");

    // stop at count 2 of period 7, start in STOP ignored
    cyc(0, 0, 1, 7, 0, 7, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    wait_cnt("reach_cnt2", 2);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (busy && n < 50) begin
      idle1();
      n++;
    end
    chk("stop_tail", n, 4);
    chk("stop_done", done, 1);

    // start > end: never high
    cyc(0, 0, 1, 20, 5, 3, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    wc = 0;
    repeat (21) begin
      wc += int'(win_out);
      idle1();
    end
    chk("inv_win", wc, 0);
    wait_idle("inv_idle");

    // end > period: clipped
    cyc(0, 0, 1, 20, 5, 30, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    wc = 0;
    repeat (21) begin
      wc += int'(win_out);
      idle1();
    end
    chk("clip_win", wc, 16);
    wait_idle("clip_idle");

    // period 0: tick every cycle
    cyc(0, 0, 1, 0, 0, 0, 4);
    cyc(1, 0, 0, 0, 0, 0, 0);
    tc = 0;
    repeat (4) begin
      tc += int'(period_tick);
      idle1();
    end
    chk("p0_ticks", tc, 4);
    chk("p0_done", done, 1);

    // reset mid-burst at count 12 of frame 2
    cyc(0, 0, 1, 20, 0, 5, 2);
    cyc(1, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (!(m_cnt == 12 && m_frm == 1) && n < 100) begin
      idle1();
      n++;
    end
    chk("reach_mid", cnt_o, 12);
    rst_n = 1'b0;
    #1;
    m_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle1();
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (25) idle1();
    cyc(0, 1, 0, 0, 0, 0, 0);
    wait_idle("post_rst_idle");

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 12) == 0,
          $urandom_range(0, 40) == 0,
          $urandom_range(0, 4) == 0,
          int'($urandom_range(0, 12)),
          int'($urandom_range(0, 14)),
          int'($urandom_range(0, 14)),
          int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
